// File: rtl/mau_lane_scheduler.sv
// MAU lane sequencer: 2-entry command queue, per-lane start-address loading, start/burst/done
// sequencing and MatRAM host arbitration (host arbitration built when MAU_SEQ_HOST_ARB_EN is defined).
module mau_lane_scheduler #(
  parameter int unsigned LANES        = 4,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned BURST_CYCLES = 4,
  parameter int unsigned HOST_MAX     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LANES*ADDR_W-1:0] cmd_base,
  output logic [ADDR_W-1:0]       lane_address,
  output logic [LANES-1:0]        lane_set,
  output logic                    mau_start,
  output logic                    busy,
  output logic                    done,
  input  logic                    host_req,
  output logic                    host_gnt
);

  localparam int unsigned BASE_W = LANES * ADDR_W;
  localparam int unsigned CNT_W  = $clog2((LANES > BURST_CYCLES) ? LANES : BURST_CYCLES) + 1;
  localparam int unsigned HCNT_W = $clog2(HOST_MAX) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [BASE_W-1:0]   work, work_nxt;
  logic [BASE_W-1:0]   q_mem [2];
  logic [1:0]          q_cnt, q_cnt_nxt;
  logic                q_nonempty;
  logic                push, pop, wr_idx;
  logic                cmd_win;
  logic [LANES-1:0]    set_nxt;
  logic [ADDR_W-1:0]   addr_nxt;

  assign q_nonempty = (q_cnt != 2'd0);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = cmd_win;
  assign wr_idx     = (q_cnt == 2'd1) && !pop;
  assign q_cnt_nxt  = q_cnt + 2'(push) - 2'(pop);

  // Command FIFO; a simultaneous pop shifts entry 1 down before the push lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_cnt    <= 2'd0;
      q_mem[0] <= '0;
      q_mem[1] <= '0;
    end else begin
      q_cnt <= q_cnt_nxt;
      if (pop)  q_mem[0]      <= q_mem[1];
      if (push) q_mem[wr_idx] <= cmd_base;
    end
  end

`ifdef MAU_SEQ_HOST_ARB_EN
  logic              last_host, last_host_nxt;
  logic [HCNT_W-1:0] hcnt, hcnt_nxt;
  logic              gnt_nxt;
  logic              hcnt_at_max;

  assign hcnt_at_max = (hcnt == HCNT_W'(HOST_MAX - 1));

  // Round-robin between host and queue, decided only in IDLE with the port released
  always_comb begin
    gnt_nxt       = 1'b0;
    hcnt_nxt      = '0;
    last_host_nxt = last_host;
    cmd_win       = 1'b0;
    if (state == IDLE) begin
      if (host_gnt) begin
        if (host_req && !(hcnt_at_max && q_nonempty)) begin
          gnt_nxt  = 1'b1;
          hcnt_nxt = hcnt_at_max ? hcnt : hcnt + HCNT_W'(1);
        end
      end else if (q_nonempty && (!host_req || last_host)) begin
        cmd_win       = 1'b1;
        last_host_nxt = 1'b0;
      end else if (host_req) begin
        gnt_nxt       = 1'b1;
        last_host_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_gnt  <= 1'b0;
      hcnt      <= '0;
      last_host <= 1'b0;
    end else begin
      host_gnt  <= gnt_nxt;
      hcnt      <= hcnt_nxt;
      last_host <= last_host_nxt;
    end
  end
`else
  logic unused_host_req;

  assign unused_host_req = host_req;
  assign host_gnt        = 1'b0;
  assign cmd_win         = (state == IDLE) && q_nonempty;
`endif

  // FSM state and working registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      work  <= work_nxt;
    end
  end

  // Next state plus next-cycle output values, registered below
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    work_nxt  = work;
    set_nxt   = '0;
    addr_nxt  = '0;
    case (state)
      IDLE: begin
        if (cmd_win) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
          work_nxt  = q_mem[0];
        end
      end
      LOAD: begin
        if (cnt == CNT_W'(LANES - 1)) state_nxt = START;
        else                          cnt_nxt   = cnt + CNT_W'(1);
      end
      START: begin
        state_nxt = RUN;
        cnt_nxt   = CNT_W'(BURST_CYCLES - 1);
      end
      RUN: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == LOAD) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (cnt_nxt == CNT_W'(i)) begin
          set_nxt[i] = 1'b1;
          addr_nxt   = work_nxt[i*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_ready    <= 1'b1;
      lane_address <= '0;
      lane_set     <= '0;
      mau_start    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      cmd_ready    <= (q_cnt_nxt != 2'd2);
      lane_address <= addr_nxt;
      lane_set     <= set_nxt;
      mau_start    <= (state_nxt == START);
      busy         <= (state_nxt != IDLE);
      done         <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_mau_lane_scheduler.sv
// Bench for mau_lane_scheduler: commands scored against a cycle-arithmetic timing model
// (LOAD start = max(accept+2, previous LOAD+11)), plus reset and host-port scenarios.
module tb_mau_lane_scheduler;

  localparam int LANES    = 4;
  localparam int ADDR_W   = 10;
  localparam int BURST    = 4;
  localparam int BASE_W   = LANES * ADDR_W;
  localparam int OP_LEN   = LANES + BURST + 2;
  localparam int OP_SPACE = LANES + BURST + 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              host_req = 1'b0;
  logic [BASE_W-1:0] cmd_base = '0;
  logic              cmd_ready, mau_start, busy, done, host_gnt;
  logic [ADDR_W-1:0] lane_address;
  logic [LANES-1:0]  lane_set;

  mau_lane_scheduler dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .lane_address(lane_address), .lane_set(lane_set),
    .mau_start(mau_start), .busy(busy), .done(done),
    .host_req(host_req), .host_gnt(host_gnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [LANES-1:0]  set;
    logic [ADDR_W-1:0] addr;
    logic              start;
    logic              done;
  } ev_t;

  int  acc_q[$];
  int  ld_q[$];
  ev_t sb[$];
  int  next_free = 0;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Queue occupancy during cycle c: accepted before c and not yet popped (pop ends cycle L-1)
  function automatic int model_occ(input int c);
    int n = 0;
    for (int i = 0; i < acc_q.size(); i++)
      if (acc_q[i] < c && ld_q[i] > c) n++;
    return n;
  endfunction

  function automatic logic model_busy(input int c);
    for (int i = 0; i < ld_q.size(); i++)
      if (ld_q[i] <= c && c <= ld_q[i] + OP_LEN - 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic accept(input logic [BASE_W-1:0] base, input int forced);
    int  l;
    ev_t e;
    l = (forced >= 0) ? forced : ((cyc + 2 > next_free) ? cyc + 2 : next_free);
    acc_q.push_back(cyc);
    ld_q.push_back(l);
    next_free = l + OP_SPACE;
    for (int k = 0; k < LANES; k++) begin
      e = '{cyc: l + k, set: LANES'(1) << k, addr: base[k*ADDR_W +: ADDR_W], start: 1'b0, done: 1'b0};
      sb.push_back(e);
    end
    e = '{cyc: l + LANES, set: '0, addr: '0, start: 1'b1, done: 1'b0};
    sb.push_back(e);
    e = '{cyc: l + LANES + BURST + 1, set: '0, addr: '0, start: 1'b0, done: 1'b1};
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [BASE_W-1:0] b, input logic h, input int forced = -1);
    @(posedge clk);
    #1;
    cmd_valid = v;
    cmd_base  = b;
    host_req  = h;
    if (v && !reset && model_occ(cyc) < 2) accept(b, forced);
  endtask

  task automatic idle(input int n, input logic h);
    for (int i = 0; i < n; i++) drive(1'b0, '0, h);
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    check({tag, "_lane_address"}, 64'(lane_address), 64'(0));
    check({tag, "_lane_set"}, 64'(lane_set), 64'(0));
    check({tag, "_mau_start"}, 64'(mau_start), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_host_gnt"}, 64'(host_gnt), 64'(0));
  endtask

  // Monitor: per-cycle model checks and scoreboard pop on every lane/start/done output
  always @(negedge clk) begin
    ev_t e;
    check("busy", 64'(busy), 64'(model_busy(cyc)));
    check("cmd_ready", 64'(cmd_ready), 64'(model_occ(cyc) < 2));
    if (lane_set == '0) check("addr_idle", 64'(lane_address), 64'(0));
`ifdef MAU_SEQ_HOST_ARB_EN
    if (host_gnt) check("gnt_while_busy", 64'(busy), 64'(0));
`else
    check("host_gnt_tied", 64'(host_gnt), 64'(0));
`endif
    if (lane_set != '0 || mau_start || done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event at cycle %0d: set=%b start=%b done=%b, expected none",
                 cyc, lane_set, mau_start, done);
      end else begin
        e = sb.pop_front();
        check("event_cycle", 64'(cyc), 64'(e.cyc));
        check("lane_set", 64'(lane_set), 64'(e.set));
        check("lane_address", 64'(lane_address), 64'(e.addr));
        check("mau_start", 64'(mau_start), 64'(e.start));
        check("done", 64'(done), 64'(e.done));
      end
    end
  end

  logic [BASE_W-1:0] base_a;
  int a, h;

  initial begin
    base_a = {10'h040, 10'h030, 10'h020, 10'h010};
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Single command with the reference bases
    drive(1'b1, base_a, 1'b0);
    idle(14, 1'b0);

    // Three back-to-back commands
    for (int i = 0; i < 3; i++) drive(1'b1, BASE_W'({$urandom, $urandom}), 1'b0);
    idle(36, 1'b0);

    // Reset asserted during the second LOAD cycle
    drive(1'b1, base_a, 1'b0);
    idle(2, 1'b0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    acc_q.delete();
    ld_q.delete();
    sb.delete();
    next_free = 0;
    @(negedge clk);
    chk_reset_vals("midload_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    idle(15, 1'b0);

    // Randomized command traffic
    for (int i = 0; i < 220; i++)
      drive($urandom_range(0, 2) == 0, BASE_W'({$urandom, $urandom}), 1'b0);
    idle(40, 1'b0);

`ifdef MAU_SEQ_HOST_ARB_EN
    // Host request arriving mid-operation waits for IDLE
    drive(1'b1, base_a, 1'b0);
    a = cyc;
    for (int i = 1; i <= 17; i++) begin
      drive(1'b0, '0, (i >= 4 && i < 15));
      @(negedge clk);
      check($sformatf("host_wait_gnt_%0d", i), 64'(host_gnt), 64'(i >= 13 && i <= 15));
    end
    idle(3, 1'b0);

    // Host grant forced low after HOST_MAX cycles once a command is pending
    drive(1'b0, '0, 1'b1);
    h = cyc;
    for (int i = 1; i <= 33; i++) begin
      if (i == 3) drive(1'b1, base_a, 1'b1, h + 18);
      else        drive(1'b0, '0, (i <= 30));
      @(negedge clk);
      check($sformatf("host_limit_gnt_%0d", i), 64'(host_gnt), 64'((i >= 1 && i <= 16) || (i >= 29 && i <= 31)));
    end
    idle(5, 1'b0);
`else
    // Host request ignored: timing identical to the plain single-command case
    drive(1'b1, base_a, 1'b1);
    idle(14, 1'b1);
    idle(3, 1'b0);
`endif

    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mau_lane_scheduler.md
# mau_lane_scheduler

Sequencer and port arbiter for the Matrix Acceleration Unit's MatRAM lanes. It accepts MAU operation commands through a 2-entry queue, each carrying one base address per lane. For each command it loads every lane controller's start address with one-hot set strobes, issues a single `mau_start` pulse, waits out the lane burst, and signals completion. It also shares MatRAM between the MAU and a host port (CPU/DMA), granting the host only while no MAU operation is in flight.

## Interface
Parameters:
- `LANES`, 4: number of MatRAM lane controllers.
- `ADDR_W`, 10: lane address width.
- `BURST_CYCLES`, 4: cycles a lane controller stays non-idle after sampling `mau_start`.
- `HOST_MAX`, 16: maximum consecutive host-grant cycles while a command is pending.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: queue not full.
- `cmd_base`, in, LANES*ADDR_W: lane i base address in bits [i*ADDR_W +: ADDR_W].
- `lane_address`, out, ADDR_W: address driven to the lane controllers' `address_in`.
- `lane_set`, out, LANES: one-hot `set_address` strobe.
- `mau_start`, out, 1: one-cycle start pulse, broadcast to all lanes.
- `busy`, out, 1: an operation is in flight.
- `done`, out, 1: one-cycle completion pulse.
- `host_req`, in, 1: host requests the MatRAM port.
- `host_gnt`, out, 1: host owns the MatRAM port.

## Operation
- Queue: 2-entry FIFO of `cmd_base`.
  - Push on `cmd_valid && cmd_ready`.
  - Pop on the IDLE→LOAD transition.
  - A push and a pop in the same cycle are allowed.
  - `cmd_ready` is low only when the queue holds 2 entries.
- FSM states: IDLE, LOAD, START, RUN, DONE.
  - IDLE→LOAD when the queue is non-empty, `host_gnt` is 0, and the command wins arbitration. The popped entry is latched into a working register.
  - LOAD lasts LANES cycles. In LOAD cycle k (k = 0..LANES-1): `lane_set` = 1<<k and `lane_address` = base[k].
  - START lasts 1 cycle with `mau_start` = 1. `lane_set` = 0.
  - RUN lasts BURST_CYCLES cycles, counted by an internal down-counter.
  - DONE lasts 1 cycle with `done` = 1, then goes to IDLE. DONE never goes directly to LOAD.
- `busy` = 1 in LOAD, START, RUN and DONE.
- `lane_address` = 0 outside LOAD.
- Arbitration (evaluated in IDLE only):
  - Round-robin between host and queue using a last-winner flag.
  - After a command completes, a requesting host wins. After a host grant ends, a pending command wins.
  - A lone requester always wins.
  - `host_gnt` rises one cycle after the winning IDLE cycle.
  - `host_gnt` holds while `host_req` = 1. It falls one cycle after `host_req` drops.
- Host limit: if `host_gnt` has been high for HOST_MAX cycles and the queue is non-empty, `host_gnt` is forced low. The next arbitration goes to the command. The host must wait and re-win.
- A host request arriving while `busy` = 1 waits. It is never granted mid-operation.
- Reset mid-operation: the queue empties, the FSM returns to IDLE, and all outputs go to their reset values. Lane controllers are reset by the same signal.

## Timing
- Reset values: `cmd_ready` = 1. `lane_address`, `lane_set`, `mau_start`, `busy`, `done` and `host_gnt` are all 0.
- All outputs are registered or decoded from state/registers only. There is no combinational path from any input to any output.
- Latency, with a command accepted at the edge ending cycle 0 and no host activity:
  - LOAD: cycles 2..LANES+1.
  - START: cycle LANES+2.
  - RUN: the next BURST_CYCLES cycles.
  - DONE: the following cycle.
  - Defaults: LOAD 2–5, START 6, RUN 7–10, DONE 11.
- Back-to-back throughput: one command per LANES+BURST_CYCLES+3 cycles (11 with defaults).
- With defaults, `mau_start` is low in every cycle where a lane is non-idle, so no lane ever sees a start mid-burst.

## Configuration
- `MAU_SEQ_HOST_ARB_EN`:
  - Defined: the host arbitration and HOST_MAX limiter are built as described.
  - Undefined: `host_gnt` is tied to 0, `host_req` is ignored, and IDLE→LOAD depends only on the queue being non-empty.

## Test plan
- Reset: assert `reset` mid-LOAD → next cycle all outputs 0, `cmd_ready` = 1, and the queue is empty (no `lane_set` activity afterward).
- Single command, bases 0x010/0x020/0x030/0x040, accepted at cycle 0 → cycles 2–5 `lane_set` = 0001/0010/0100/1000 with matching `lane_address`; `mau_start` at cycle 6; `done` at cycle 11; `busy` high for cycles 2–11.
- Three commands offered at cycles 0, 1, 2 → all accepted; `cmd_ready` = 0 from cycle 3 through cycle 12 and = 1 at cycle 13; second LOAD starts at cycle 13; third `done` at cycle 33.
- `host_req` raised at cycle 4 during the single-command case → `host_gnt` = 0 through cycle 12 and = 1 at cycle 13; drop `host_req` at cycle 15 → `host_gnt` = 0 at cycle 16.
- Host holding grant with a command pushed → `host_gnt` forced low after 16 grant cycles; LOAD starts two cycles later; `host_gnt` stays low until that command's DONE.
- Build without `MAU_SEQ_HOST_ARB_EN` and `host_req` held at 1 → `host_gnt` stays 0; the single-command timing is identical to the second scenario.
